hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core. Generates the enable, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts a configurable number of bubbles. Squashes wrong-path instructions on a taken branch or jump resolved in EX.
- Freezes the whole pipeline while data memory is busy.
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 40 ++++
 rtl/hazard_ctrl_sat_counter.sv | 41 ++++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard sequencer
//
// Purpose : state encoding, register-index constant and event priority
//           encoding used by hazard_ctrl.
// Contents: state_e    - sequencer FSM states (RUN, LU_STALL)
//           REG_ZERO   - architectural zero register index (never a hazard)
//           BUB_W      - width of the bubble down-counter
//           event_e    - pipeline events, ordered by priority
//           classify() - reduce raw conditions to the single winning event
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int unsigned BUB_W = 3;

  // Larger encoding means higher priority.
  typedef enum logic [1:0] {
    EV_NONE     = 2'd0,
    EV_LOAD_USE = 2'd1,
    EV_REDIRECT = 2'd2,
    EV_MEM_BUSY = 2'd3
  } event_e;

  // A held memory access outranks everything because no stage can advance;
  // a redirect outranks a load-use stall because the stalled instruction is
  // on the wrong path anyway.
  function automatic event_e classify(input logic mem_busy,
                                      input logic redirect,
                                      input logic stalling);
    if (mem_busy)      return EV_MEM_BUSY;
    else if (redirect) return EV_REDIRECT;
    else if (stalling) return EV_LOAD_USE;
    else               return EV_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter with synchronous clear
//
// Purpose : counts cycles in which inc_i is high, sticking at all-ones.
// Ports   : clk_i   - clock, rising edge
//           rst_ni  - asynchronous active-low reset (count -> 0)
//           clr_i   - synchronous clear, wins over inc_i
//           inc_i   - increment request
//           count_o - current count
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush/bubble sequencer
//
// Purpose : drives the enable/flush/bubble controls of the PC and the four
//           pipeline registers; inserts load-use bubbles, squashes wrong-path
//           instructions on an EX redirect, freezes on a busy data memory and
//           keeps stall/flush performance counters.
// Ports   : clk, reset (async, active-low)
//           id_rs1/id_rs2/id_use_rs1/id_use_rs2 - ID source operands
//           ex_rd/ex_load                        - EX destination and load flag
//           ex_redirect                          - taken branch/jump in EX
//           mem_busy                             - MEM stage cannot complete
//           perf_clr                             - clear both counters
//           pc_en, if_id_en, if_id_flush, id_ex_hold, id_ex_bubble,
//           ex_mem_en, mem_wb_bubble             - pipeline controls
//           stall_cycles, flush_count            - saturating counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // The first bubble is issued from RUN, so LU_STALL covers the remainder.
  localparam logic [BUB_W-1:0] LU_RELOAD = BUB_W'(LOAD_USE_CYCLES - 1);
  localparam bit               MULTI_BUB = (LOAD_USE_CYCLES > 1);

  state_e           state_q, state_d;
  logic [BUB_W-1:0] bub_cnt_q, bub_cnt_d;
  logic             lu;
  event_e           ev;
  logic             flush_inc;

  assign lu = ex_load && (ex_rd != REG_ZERO) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  // While in LU_STALL the hazard is not re-evaluated: the stall runs its
  // full length even if the ID operands change underneath it.
  assign ev = classify(mem_busy, ex_redirect, lu || (state_q == LU_STALL));

  always_comb begin
    state_d       = state_q;
    bub_cnt_d     = bub_cnt_q;
    flush_inc     = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;

    unique case (ev)
      EV_MEM_BUSY: begin
        // Front end and EX hold; MEM/WB sees a NOP so WB does not repeat
        // the stalled instruction. FSM and bubble count stay frozen.
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_hold    = 1'b1;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      EV_REDIRECT: begin
        // IF/ID loads a NOP and ID/EX gets a bubble; the PC takes the target.
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
        bub_cnt_d    = '0;
        flush_inc    = 1'b1;
      end
      EV_LOAD_USE: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        if (state_q == RUN) begin
          if (MULTI_BUB) begin
            state_d   = LU_STALL;
            bub_cnt_d = LU_RELOAD;
          end
        end else if (bub_cnt_q <= BUB_W'(1)) begin
          state_d   = RUN;
          bub_cnt_d = '0;
        end else begin
          bub_cnt_d = bub_cnt_q - BUB_W'(1);
        end
      end
      default: begin
      end
    endcase

    // Reset drives every register to a safe NOP-loading configuration.
    if (!reset) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_hold    = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      flush_inc     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      bub_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (perf_clr),
    .inc_i   (!pc_en),
    .count_o (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (perf_clr),
    .inc_i   (flush_inc),
    .count_o (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam bit D1 = 1'b0;  // LOAD_USE_CYCLES=1, 32-bit counters
  localparam bit D3 = 1'b1;  // LOAD_USE_CYCLES=3, 4-bit counters

  // {pc_en, if_id_en, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_en, mem_wb_bubble}
  localparam logic [6:0] O_RST = 7'b0010101;
  localparam logic [6:0] O_RUN = 7'b1100010;
  localparam logic [6:0] O_LU  = 7'b0000110;
  localparam logic [6:0] O_RED = 7'b1110110;
  localparam logic [6:0] O_BSY = 7'b0001001;

  typedef struct {
    bit         d;
    bit         rstn;
    logic [4:0] rs1, rs2, rd;
    bit         u1, u2, ld, redir, busy, clr;
    logic [6:0] o;
    int         st, fl;
  } vec_t;

  typedef struct {
    bit         d;
    logic [6:0] o;
    int         st, fl;
    int         idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [4:0] rs1_a, rs2_a, rd_a, rs1_b, rs2_b, rd_b;
  logic u1_a, u2_a, ld_a, redir_a, busy_a, clr_a;
  logic u1_b, u2_b, ld_b, redir_b, busy_b, clr_b;
  logic [6:0] o_a, o_b;
  logic [31:0] st_a, fl_a;
  logic [3:0]  st_b, fl_b;

  vec_t vq[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset),
    .id_rs1(rs1_a), .id_rs2(rs2_a), .id_use_rs1(u1_a), .id_use_rs2(u2_a),
    .ex_rd(rd_a), .ex_load(ld_a), .ex_redirect(redir_a), .mem_busy(busy_a),
    .perf_clr(clr_a),
    .pc_en(o_a[6]), .if_id_en(o_a[5]), .if_id_flush(o_a[4]), .id_ex_hold(o_a[3]),
    .id_ex_bubble(o_a[2]), .ex_mem_en(o_a[1]), .mem_wb_bubble(o_a[0]),
    .stall_cycles(st_a), .flush_count(fl_a)
  );

  hazard_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset),
    .id_rs1(rs1_b), .id_rs2(rs2_b), .id_use_rs1(u1_b), .id_use_rs2(u2_b),
    .ex_rd(rd_b), .ex_load(ld_b), .ex_redirect(redir_b), .mem_busy(busy_b),
    .perf_clr(clr_b),
    .pc_en(o_b[6]), .if_id_en(o_b[5]), .if_id_flush(o_b[4]), .id_ex_hold(o_b[3]),
    .id_ex_bubble(o_b[2]), .ex_mem_en(o_b[1]), .mem_wb_bubble(o_b[0]),
    .stall_cycles(st_b), .flush_count(fl_b)
  );

  task automatic vec(input bit d, input bit rstn, input logic [4:0] rs1, input logic [4:0] rs2,
                     input bit u1, input bit u2, input logic [4:0] rd, input bit ld,
                     input bit redir, input bit busy, input bit clr,
                     input logic [6:0] o, input int st, input int fl);
    vec_t v;
    v.d = d; v.rstn = rstn; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.ld = ld; v.redir = redir; v.busy = busy; v.clr = clr;
    v.o = o; v.st = st; v.fl = fl;
    vq.push_back(v);
  endtask

  // load r5 in EX, ID reads r5 through rs1
  task automatic haz(input bit d, input logic [6:0] o, input int st, input int fl);
    vec(d, 1, 5, 0, 1, 0, 5, 1, 0, 0, 0, o, st, fl);
  endtask

  task automatic ev(input bit d, input bit redir, input bit busy, input bit clr,
                    input logic [6:0] o, input int st, input int fl);
    vec(d, 1, 0, 0, 0, 0, 0, 0, redir, busy, clr, o, st, fl);
  endtask

  task automatic idl(input bit d, input logic [6:0] o, input int st, input int fl);
    ev(d, 0, 0, 0, o, st, fl);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rstn;
    rs1_a = v.d ? 5'd0 : v.rs1;  rs1_b = v.d ? v.rs1 : 5'd0;
    rs2_a = v.d ? 5'd0 : v.rs2;  rs2_b = v.d ? v.rs2 : 5'd0;
    rd_a  = v.d ? 5'd0 : v.rd;   rd_b  = v.d ? v.rd  : 5'd0;
    u1_a = !v.d && v.u1;   u1_b = v.d && v.u1;
    u2_a = !v.d && v.u2;   u2_b = v.d && v.u2;
    ld_a = !v.d && v.ld;   ld_b = v.d && v.ld;
    redir_a = !v.d && v.redir; redir_b = v.d && v.redir;
    busy_a  = !v.d && v.busy;  busy_b  = v.d && v.busy;
    clr_a   = !v.d && v.clr;   clr_b   = v.d && v.clr;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, sample mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.d) begin
          check("ctrl3", e.idx, {25'd0, o_b}, {25'd0, e.o});
          check("stall3", e.idx, {28'd0, st_b}, 32'(e.st));
          check("flush3", e.idx, {28'd0, fl_b}, 32'(e.fl));
        end else begin
          check("ctrl1", e.idx, {25'd0, o_a}, {25'd0, e.o});
          check("stall1", e.idx, st_a, 32'(e.st));
          check("flush1", e.idx, fl_a, 32'(e.fl));
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n;
    exp_t e;
    vec_t v0;
    v0 = '{d: D1, rstn: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, u1: 1'b0, u2: 1'b0,
           ld: 1'b0, redir: 1'b0, busy: 1'b0, clr: 1'b0, o: 7'd0, st: 0, fl: 0};
    drive(v0);

    // LOAD_USE_CYCLES = 1
    vec(D1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 0);
    idl(D1, O_RUN, 0, 0);
    haz(D1, O_LU, 0, 0);
    idl(D1, O_RUN, 1, 0);
    vec(D1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, O_RUN, 1, 0);   // load to r0: no hazard
    vec(D1, 1, 3, 7, 1, 1, 7, 1, 0, 0, 0, O_LU, 1, 0);    // hazard via rs2
    vec(D1, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0, O_RUN, 2, 0);   // rs1 match but unused
    vec(D1, 1, 5, 0, 1, 0, 5, 0, 0, 0, 0, O_RUN, 2, 0);   // not a load

    // LOAD_USE_CYCLES = 3: three-cycle stall
    haz(D3, O_LU, 0, 0);
    idl(D3, O_LU, 1, 0);
    idl(D3, O_LU, 2, 0);
    idl(D3, O_RUN, 3, 0);
    // redirect in the second stall cycle aborts the stall
    haz(D3, O_LU, 3, 0);
    ev(D3, 1, 0, 0, O_RED, 4, 0);
    idl(D3, O_RUN, 4, 1);
    ev(D3, 0, 0, 1, O_RUN, 4, 1);
    idl(D3, O_RUN, 0, 0);
    // mem_busy outranks a pending redirect for 4 cycles
    for (int i = 0; i < 4; i++) ev(D3, 1, 1, 0, O_BSY, i, 0);
    ev(D3, 1, 0, 0, O_RED, 4, 0);
    idl(D3, O_RUN, 4, 1);
    // mem_busy freezes an in-progress load-use stall
    haz(D3, O_LU, 4, 1);
    ev(D3, 0, 1, 0, O_BSY, 5, 1);
    idl(D3, O_LU, 6, 1);
    idl(D3, O_LU, 7, 1);
    idl(D3, O_RUN, 8, 1);
    // drive the 4-bit stall counter into saturation
    haz(D3, O_LU, 8, 1);
    idl(D3, O_LU, 9, 1);
    idl(D3, O_LU, 10, 1);
    haz(D3, O_LU, 11, 1);
    idl(D3, O_LU, 12, 1);
    idl(D3, O_LU, 13, 1);
    haz(D3, O_LU, 14, 1);
    idl(D3, O_LU, 15, 1);
    idl(D3, O_LU, 15, 1);
    idl(D3, O_RUN, 15, 1);
    ev(D3, 0, 0, 1, O_RUN, 15, 1);
    idl(D3, O_RUN, 0, 0);
    // reset in the middle of a stall
    haz(D3, O_LU, 0, 0);
    vec(D3, 0, 5, 0, 1, 0, 5, 1, 0, 0, 0, O_RST, 0, 0);
    idl(D3, O_RUN, 0, 0);
    idl(D3, O_RUN, 0, 0);

    n = 0;
    while (vq.size() > 0) begin
      @(posedge clk);
      #1;
      drive(vq[0]);
      e.d = vq[0].d; e.o = vq[0].o; e.st = vq[0].st; e.fl = vq[0].fl; e.idx = n;
      sb.push_back(e);
      void'(vq.pop_front());
      n++;
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
